// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, latency defaults, decode helpers.
// Optional build macro: MDU_MADD_EN (adds MADD/MADDU/MSUB/MSUBU to the start class).
package md_unit_pkg;

  localparam int DATA_W          = 32;
  localparam int CNT_W           = 8;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [3:0] {
    MD_NONE = 4'd0,
    MULT    = 4'd1,
    MULTU   = 4'd2,
    DIV     = 4'd3,
    DIVU    = 4'd4,
    MFHI    = 4'd5,
    MFLO    = 4'd6,
    MTHI    = 4'd7,
    MTLO    = 4'd8,
    MADD    = 4'd9,
    MADDU   = 4'd10,
    MSUB    = 4'd11,
    MSUBU   = 4'd12
  } md_op_e;

  function automatic logic is_start_class(input md_op_e op);
    case (op)
      MULT, MULTU, DIV, DIVU: return 1'b1;
`ifdef MDU_MADD_EN
      MADD, MADDU, MSUB, MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_class(input md_op_e op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage bundle between the pipeline and the multiply/divide unit.
interface md_unit_if;
  import md_unit_pkg::*;

  md_op_e      md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  modport master (
    output md_op, rs_val, rt_val, flush,
    input  start, busy, hi, lo, rd_data
  );

  modport slave (
    input  md_op, rs_val, rt_val, flush,
    output start, busy, hi, lo, rd_data
  );
endinterface

// File: rtl/md_unit_timer.sv
// Latency down-counter for the multiply/divide unit; done pulses in the last busy cycle.
module md_timer
  import md_unit_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_busy,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_load) begin
      r_cnt  <= i_load_val;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CNT_W'(1)) r_busy <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/md_unit.sv
// HI/LO owner for the MIPS E stage: decodes MD ops, computes results at accept, commits after a fixed latency.
// Optional build macro: MDU_MADD_EN (multiply-accumulate/subtract ops).
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic     clk,
  input  logic     reset,
  md_unit_if.slave md
);

  localparam logic [CNT_W-1:0] L_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] L_DIV  = CNT_W'(DIV_CYCLES);

  logic [31:0] r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic        r_pend_vld;

  logic               w_busy, w_done, w_start, w_div0, w_ovf, w_commit_en;
  logic [CNT_W-1:0]   w_load_val;
  logic signed [31:0] w_rs_s, w_rt_safe_s, w_quot_s, w_rem_s;
  logic [31:0]        w_rt_safe_u, w_quot_u, w_rem_u;
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u, w_result;
  logic [31:0]        w_rd_data;

  md_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_start),
    .i_load_val (w_load_val),
    .o_busy     (w_busy),
    .o_done     (w_done)
  );

  // Gated by reset so nothing is reported as accepted while the unit is held in reset.
  assign w_start    = is_start_class(md.md_op) && !w_busy && !md.flush && reset;
  assign w_load_val = is_div_class(md.md_op) ? L_DIV : L_MULT;

  assign w_rs_s   = $signed(md.rs_val);
  assign w_prod_s = $signed({{32{md.rs_val[31]}}, md.rs_val}) *
                    $signed({{32{md.rt_val[31]}}, md.rt_val});
  assign w_prod_u = {32'b0, md.rs_val} * {32'b0, md.rt_val};

  // Divisor is forced to 1 for /0 (result discarded) and for MIN/-1, where x/1 is exactly the required answer.
  assign w_div0      = (md.rt_val == 32'h0);
  assign w_ovf       = (md.rs_val == 32'h8000_0000) && (md.rt_val == 32'hFFFF_FFFF);
  assign w_rt_safe_s = (w_div0 || w_ovf) ? 32'sd1 : $signed(md.rt_val);
  assign w_rt_safe_u = w_div0 ? 32'd1 : md.rt_val;
  assign w_quot_s    = w_rs_s / w_rt_safe_s;
  assign w_rem_s     = w_rs_s % w_rt_safe_s;
  assign w_quot_u    = md.rs_val / w_rt_safe_u;
  assign w_rem_u     = md.rs_val % w_rt_safe_u;

  assign w_commit_en = !(is_div_class(md.md_op) && w_div0);

  always_comb begin
    w_result = {r_hi, r_lo};
    case (md.md_op)
      MULT:  w_result = $unsigned(w_prod_s);
      MULTU: w_result = w_prod_u;
      DIV:   w_result = {$unsigned(w_rem_s), $unsigned(w_quot_s)};
      DIVU:  w_result = {w_rem_u, w_quot_u};
`ifdef MDU_MADD_EN
      MADD:  w_result = {r_hi, r_lo} + $unsigned(w_prod_s);
      MADDU: w_result = {r_hi, r_lo} + w_prod_u;
      MSUB:  w_result = {r_hi, r_lo} - $unsigned(w_prod_s);
      MSUBU: w_result = {r_hi, r_lo} - w_prod_u;
`endif
      default: w_result = {r_hi, r_lo};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_pend_hi  <= '0;
      r_pend_lo  <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      if (w_start) begin
        r_pend_hi  <= w_result[63:32];
        r_pend_lo  <= w_result[31:0];
        r_pend_vld <= w_commit_en;
      end
      // done implies busy, so a commit and an MTHI/MTLO write never collide.
      if (w_done) begin
        if (r_pend_vld) begin
          r_hi <= r_pend_hi;
          r_lo <= r_pend_lo;
        end
      end else if (!w_busy && !md.flush) begin
        if (md.md_op == MTHI) r_hi <= md.rs_val;
        if (md.md_op == MTLO) r_lo <= md.rs_val;
      end
    end
  end

  always_comb begin
    w_rd_data = 32'h0;
    case (md.md_op)
      MFHI:    w_rd_data = r_hi;
      MFLO:    w_rd_data = r_lo;
      default: w_rd_data = 32'h0;
    endcase
  end

  assign md.start   = w_start;
  assign md.busy    = w_busy;
  assign md.hi      = r_hi;
  assign md.lo      = r_lo;
  assign md.rd_data = w_rd_data;

endmodule

// File: tb/tb_md_unit.sv
// Directed table-driven bench for md_unit plus hand sequences for reset, flush and busy-time corner cases.
module tb_md_unit;
  import md_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_unit_if md();

  md_unit dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  int n_pass = 0;
  int n_chk  = 0;

  typedef struct {
    md_op_e      op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        st;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic put(input md_op_e op, input logic [31:0] rs, input logic [31:0] rt, input logic fl);
    @(negedge clk);
    md.md_op  = op;
    md.rs_val = rs;
    md.rt_val = rt;
    md.flush  = fl;
    #1;
  endtask

  // Caller sits at a negedge with MD_NONE driven; counts busy cycles up to a bound.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (md.busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  int cnt;

  initial begin
    tv.push_back('{MULT,  32'hFFFF_FFFF, 32'h2,         1'b1, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFE});
    tv.push_back('{MULTU, 32'hFFFF_FFFF, 32'h2,         1'b1, 5,  32'h0000_0001, 32'hFFFF_FFFE});
    tv.push_back('{DIVU,  32'h7,         32'h2,         1'b1, 10, 32'h1,         32'h3});
    tv.push_back('{DIV,   32'h9,         32'h0,         1'b1, 10, 32'h1,         32'h3});
    tv.push_back('{DIV,   32'hFFFF_FFF9, 32'h2,         1'b1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    tv.push_back('{DIV,   32'h7,         32'hFFFF_FFFE, 1'b1, 10, 32'h1,         32'hFFFF_FFFD});
    tv.push_back('{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 10, 32'h0,         32'h8000_0000});
    tv.push_back('{DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 10, 32'h8000_0000, 32'h0});
    tv.push_back('{MULT,  32'h8000_0000, 32'h8000_0000, 1'b1, 5,  32'h4000_0000, 32'h0});
    tv.push_back('{MULT,  32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 5,  32'hFFFF_FFFF, 32'hEDCB_A988});
    tv.push_back('{MTHI,  32'h1234,      32'h0,         1'b0, 0,  32'h1234,      32'hEDCB_A988});
    tv.push_back('{MTLO,  32'hFFFF_FFFF, 32'h0,         1'b0, 0,  32'h1234,      32'hFFFF_FFFF});
    tv.push_back('{MTHI,  32'h0,         32'h0,         1'b0, 0,  32'h0,         32'hFFFF_FFFF});
`ifdef MDU_MADD_EN
    tv.push_back('{MADDU, 32'h1,         32'h1,         1'b1, 5,  32'h1,         32'h0});
    tv.push_back('{MSUB,  32'h1,         32'h1,         1'b1, 5,  32'h0,         32'hFFFF_FFFF});
`else
    tv.push_back('{MADDU, 32'h1,         32'h1,         1'b0, 0,  32'h0,         32'hFFFF_FFFF});
    tv.push_back('{MSUB,  32'h1,         32'h1,         1'b0, 0,  32'h0,         32'hFFFF_FFFF});
`endif

    // Reset held with a start-class op present
    reset     = 1'b0;
    md.md_op  = MULT;
    md.rs_val = 32'h3;
    md.rt_val = 32'h5;
    md.flush  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_start", 64'(md.start), 64'(1'b0));
    chk("reset_busy",  64'(md.busy),  64'(1'b0));
    chk("reset_hi",    64'(md.hi),    64'h0);
    chk("reset_lo",    64'(md.lo),    64'h0);
    md.md_op = MD_NONE;
    #1;
    chk("reset_rd_none", 64'(md.rd_data), 64'h0);
    @(negedge clk);
    reset = 1'b1;

    foreach (tv[i]) begin
      put(tv[i].op, tv[i].rs, tv[i].rt, 1'b0);
      chk($sformatf("v%0d_start", i), 64'(md.start), 64'(tv[i].st));
      @(negedge clk);
      md.md_op = MD_NONE;
      wait_idle(cnt);
      chk($sformatf("v%0d_busy_cycles", i), 64'(cnt), 64'(tv[i].cyc));
      chk($sformatf("v%0d_hi", i), 64'(md.hi), 64'(tv[i].hi));
      chk($sformatf("v%0d_lo", i), 64'(md.lo), 64'(tv[i].lo));
      put(MFHI, 32'h0, 32'h0, 1'b0);
      chk($sformatf("v%0d_mfhi", i), 64'(md.rd_data), 64'(tv[i].hi));
      put(MFLO, 32'h0, 32'h0, 1'b0);
      chk($sformatf("v%0d_mflo", i), 64'(md.rd_data), 64'(tv[i].lo));
    end

    // mfhi/mflo directly after mthi/mtlo
    put(MTHI, 32'h0000_1234, 32'h0, 1'b0);
    put(MFHI, 32'h0, 32'h0, 1'b0);
    chk("mthi_then_mfhi", 64'(md.rd_data), 64'h1234);
    put(MTLO, 32'h5, 32'h0, 1'b0);
    put(MFLO, 32'h0, 32'h0, 1'b0);
    chk("mtlo_then_mflo", 64'(md.rd_data), 64'h5);

    // MTLO dropped while busy; MFLO during busy sees the architectural value
    put(MULTU, 32'h2, 32'h3, 1'b0);
    chk("mulu_start", 64'(md.start), 64'(1'b1));
    put(MD_NONE, 32'h0, 32'h0, 1'b0);
    put(MTLO, 32'hAAAA, 32'h0, 1'b0);
    put(MFLO, 32'h0, 32'h0, 1'b0);
    chk("busy_mtlo_dropped", 64'(md.lo), 64'h5);
    chk("busy_mflo_arch", 64'(md.rd_data), 64'h5);
    @(negedge clk);
    md.md_op = MD_NONE;
    wait_idle(cnt);
    chk("mulu_after_hi", 64'(md.hi), 64'h0);
    chk("mulu_after_lo", 64'(md.lo), 64'h6);

    // flush suppresses acceptance
    put(MULT, 32'h3, 32'h3, 1'b1);
    chk("flush_start", 64'(md.start), 64'(1'b0));
    put(MD_NONE, 32'h0, 32'h0, 1'b0);
    chk("flush_busy", 64'(md.busy), 64'(1'b0));
    chk("flush_lo", 64'(md.lo), 64'h6);
    put(MTHI, 32'hDEAD, 32'h0, 1'b1);
    put(MD_NONE, 32'h0, 32'h0, 1'b0);
    chk("flush_mthi", 64'(md.hi), 64'h0);

    // Back-to-back: new start accepted in the first non-busy cycle
    put(MULT, 32'h2, 32'h2, 1'b0);
    @(negedge clk);
    md.md_op = MD_NONE;
    wait_idle(cnt);
    chk("b2b_first_cycles", 64'(cnt), 64'd5);
    md.md_op  = MULT;
    md.rs_val = 32'h3;
    md.rt_val = 32'h3;
    #1;
    chk("b2b_first_lo", 64'(md.lo), 64'h4);
    chk("b2b_second_start", 64'(md.start), 64'(1'b1));
    @(negedge clk);
    md.md_op = MD_NONE;
    wait_idle(cnt);
    chk("b2b_second_cycles", 64'(cnt), 64'd5);
    chk("b2b_second_lo", 64'(md.lo), 64'h9);

    // Reset during busy cycle 3 of a DIV: no commit afterwards
    put(DIV, 32'd100, 32'd7, 1'b0);
    put(MD_NONE, 32'h0, 32'h0, 1'b0);
    put(MD_NONE, 32'h0, 32'h0, 1'b0);
    put(MD_NONE, 32'h0, 32'h0, 1'b0);
    chk("midrst_busy_before", 64'(md.busy), 64'(1'b1));
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(md.busy), 64'(1'b0));
    chk("midrst_hi", 64'(md.hi), 64'h0);
    chk("midrst_lo", 64'(md.lo), 64'h0);
    repeat (12) @(negedge clk);
    chk("midrst_no_commit", {md.hi, md.lo}, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
